barrett_mu_precompute: RTL and testbench

//  Sequential producer of the Barrett constants for the modular-multiply path.

---
 rtl/barrett_mu_precompute.sv | 172 +++++++++++++++++
 tb/tb_barrett_mu_precompute.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/barrett_mu_precompute.sv
// barrett_mu_precompute
// Produces the Barrett constants k = ceil(log2 q) and mu = floor(2^(2k) / q)
// for the modular-multiply reduction stage, using a radix-2 restoring divider
// that retires one dividend bit per cycle.
//
// Optional feature: define MU_CACHE_EN to keep the last successful modulus.
// A repeated request for that modulus then skips the divide.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; captures q when start is seen
// LOAD  | encodes k from q-1, clears the divider, loads count = 2k+1
// DIV   | one restoring-divide step per cycle, MSB of 2^(2k) first
// FIN   | done pulse; k/mu/err were updated on the edge entering FIN
module barrett_mu_precompute #(
  parameter int W  = 64,
  parameter int KW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [KW-1:0] k,
  output logic [W:0]    mu
);

  localparam int CW = KW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, FIN} state_t;

  state_t        state, next_state;
  logic [W-1:0]  q_reg;
  logic [W:0]    rem;
  logic [W:0]    quo;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k_calc;

  logic [W-1:0]  q_m1;
  logic [KW-1:0] k_enc;
  logic          div_bit;
  logic [W:0]    rem_sh;
  logic          rem_ge;
  logic [W:0]    rem_nx;
  logic [W:0]    quo_nx;
  logic          cache_hit;

`ifdef MU_CACHE_EN
  logic [W-1:0]  last_q;
  logic          last_valid;

  // Hit only when a prior successful divide used the same nonzero modulus.
  always_comb begin
    cache_hit = last_valid && (q == last_q) && (q != '0);
  end

  // Remember the modulus of the most recent successful computation; an
  // error result overwrites k/mu with 0, so it must also drop the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      last_valid <= 1'b0;
    end else if (state == DIV && next_state == FIN) begin
      last_q     <= q_reg;
      last_valid <= 1'b1;
    end else if (state == IDLE && next_state == FIN && q == '0) begin
      last_valid <= 1'b0;
    end
  end
`else
  // Without the cache every request runs the full divide.
  always_comb begin
    cache_hit = 1'b0;
  end
`endif

  // Priority encode of q-1 gives its bit length, i.e. ceil(log2 q).
  always_comb begin
    q_m1  = q_reg - 1'b1;
    k_enc = '0;
    for (int i = 0; i < W; i++) begin
      if (q_m1[i]) k_enc = KW'(i + 1);
    end
  end

  // One restoring-divide step; the dividend's only 1 is its first bit.
  always_comb begin
    div_bit = (cnt == {k_calc, 1'b1});
    rem_sh  = {rem[W-1:0], div_bit};
    rem_ge  = (rem_sh >= {1'b0, q_reg});
    rem_nx  = rem_ge ? (rem_sh - {1'b0, q_reg}) : rem_sh;
    quo_nx  = {quo[W-1:0], rem_ge};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (q == '0 || cache_hit) next_state = FIN;
          else                      next_state = LOAD;
        end
      end
      LOAD:    next_state = DIV;
      DIV:     if (cnt == CW'(1)) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Divider datapath: capture, initialise, iterate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg  <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      k_calc <= '0;
    end else begin
      case (state)
        IDLE: if (start) q_reg <= q;
        LOAD: begin
          k_calc <= k_enc;
          rem    <= '0;
          quo    <= '0;
          cnt    <= {k_enc, 1'b1};
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered so k/mu/err are stable in the same cycle as done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      k    <= '0;
      mu   <= '0;
    end else begin
      busy <= (next_state == LOAD) || (next_state == DIV);
      done <= (next_state == FIN);
      if (next_state == FIN) begin
        if (state == DIV) begin
          err <= 1'b0;
          k   <= k_calc;
          mu  <= quo_nx;
        end else if (state == IDLE && q == '0) begin
          err <= 1'b1;
          k   <= '0;
          mu  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_barrett_mu_precompute.sv
// Bench for barrett_mu_precompute: directed corner cases plus random moduli
// checked against a plain-arithmetic model of k and mu.
module tb_barrett_mu_precompute;

  localparam int W  = 64;
  localparam int KW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  q = '0;
  logic          busy, done, err;
  logic [KW-1:0] k;
  logic [W:0]    mu;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] c_last = '0;
  logic         c_valid = 1'b0;

  barrett_mu_precompute #(.W(W), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q),
    .busy(busy), .done(done), .err(err), .k(k), .mu(mu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_k(input logic [W-1:0] qq);
    logic [W:0] p;
    int kk;
    p = 1;
    kk = 0;
    while (p < {1'b0, qq}) begin
      p = p << 1;
      kk++;
    end
    return kk;
  endfunction

  function automatic logic [W:0] ref_mu(input logic [W-1:0] qq);
    logic [2*W+1:0] num;
    logic [2*W+1:0] quot;
    num  = '0;
    num[2*ref_k(qq)] = 1'b1;
    quot = num / {{(W+2){1'b0}}, qq};
    return quot[W:0];
  endfunction

  // Issues one request at the current cycle (cycle 0) and checks the result.
  task automatic run(input logic [W-1:0] qq, input string tag);
    int n, exp_lat, kk;
    logic [W:0] exp_mu;
    logic exp_err;
    logic hit;
    hit = 1'b0;
`ifdef MU_CACHE_EN
    hit = c_valid && (qq == c_last) && (qq != '0);
`endif
    if (qq == '0) begin
      kk = 0; exp_mu = '0; exp_err = 1'b1; exp_lat = 1;
    end else begin
      kk = ref_k(qq); exp_mu = ref_mu(qq); exp_err = 1'b0;
      exp_lat = hit ? 1 : 2 * kk + 3;
    end
    start = 1'b1;
    q = qq;
    @(posedge clk); #1;
    start = 1'b0;
    q = $urandom();
    n = 1;
    if (exp_lat > 1) chk({tag, ":busy_c1"}, {64'd0, busy}, 65'd1);
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":latency"}, W'(n), W'(exp_lat));
    chk({tag, ":done"}, {64'd0, done}, 65'd1);
    chk({tag, ":busy_fin"}, {64'd0, busy}, 65'd0);
    chk({tag, ":err"}, {64'd0, err}, {64'd0, exp_err});
    chk({tag, ":k"}, (W+1)'(k), (W+1)'(kk));
    chk({tag, ":mu"}, mu, exp_mu);
    if (qq == '0) c_valid = 1'b0;
    else begin c_valid = 1'b1; c_last = qq; end
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, {64'd0, done}, 65'd0);
  endtask

  initial begin
    int n;
    logic saw_done;
    logic [W-1:0] rq;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:busy", {64'd0, busy}, 65'd0);
    chk("reset:done", {64'd0, done}, 65'd0);
    chk("reset:err", {64'd0, err}, 65'd0);
    chk("reset:k", (W+1)'(k), 65'd0);
    chk("reset:mu", mu, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run(64'd3, "q3");
    chk("q3:mu_const", mu, 65'd5);
    run(64'd1, "q1");
    run(64'd0, "q0");
    run(64'd3, "q3_after_err");
    run(64'h8000_0000_0000_0000, "q2p63");
    run(64'hFFFF_FFFF_FFFF_FFFF, "qmax");
    chk("qmax:mu_const", mu, 65'h1_0000_0000_0000_0001);
    run(64'd2, "q2");
    run(64'd4, "q4");
    run(64'd5, "q5");

    // Repeat of the previous modulus: cache hit only if the cache is built in.
    run(64'd5, "q5_repeat");

    // A start while busy must be ignored.
    start = 1'b1; q = 64'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; q = 64'd9;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (!done && n < 300) begin @(posedge clk); #1; n++; end
    chk("busy_ignore:latency", W'(n), W'(7));
    chk("busy_ignore:mu", mu, 65'd5);
    c_valid = 1'b1; c_last = 64'd3;
    @(posedge clk); #1;

    // Reset mid-divide aborts with no done pulse.
    start = 1'b1; q = 64'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c_valid = 1'b0;
    #1;
    chk("abort:busy", {64'd0, busy}, 65'd0);
    chk("abort:k", (W+1)'(k), 65'd0);
    chk("abort:mu", mu, 65'd0);
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort:no_done", {64'd0, saw_done}, 65'd0);
    run(64'd7, "q7_after_abort");
    chk("q7:mu_const", mu, 65'd9);

    for (int i = 0; i < 24; i++) begin
      rq = {$urandom(), $urandom()};
      rq = rq >> $urandom_range(0, 63);
      if (i % 6 == 5) rq = rq | 64'h8000_0000_0000_0000;
      run(rq, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
